u409_cycle_term_ctrl: RTL and testbench

Central cycle-termination sequencer for MC68040/MC68060 slave cycles decoded by U409. It arbitrates four local slave spaces: ROM, CIA, local registers and autoconfig. For each claimed cycle it drives nTA, nTBI and nTEA through one state machine, using per-space wait-state timing and an optional external ready. A bus watchdog terminates hung cycles with nTEA, and the block guarantees one actively driven negation cycle before it releases the bus.

---
 rtl/u409_cycle_term_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_u409_cycle_term_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/u409_cycle_term_ctrl.sv
// ----------------------------------------------------------------------------
// u409_cycle_term_ctrl
//
// Cycle-termination sequencer for MC68040/MC68060 slave cycles that U409
// decodes into one of four local spaces (ROM, CIA, local registers,
// autoconfig). A claimed cycle waits out a per-space wait count and, where
// the space needs it, an external ready. It then acknowledges with nTA/nTBI.
// A hung cycle is ended with nTEA by a watchdog. After either termination the
// pads are driven high for one cycle before they are released.
//
// Ports:
//   CLK40    in   40 MHz CPU bus clock, all state on the rising edge
//   nRESET   in   asynchronous active-low reset
//   TS       in   transfer start pulse, active high
//   SPACE    in   [3:0] decoded space selects: 0 ROM, 1 CIA, 2 REG, 3 ACFG
//   EXT_RDY  in   [3:0] per-space external ready, synchronous to CLK40
//   nTA      out  transfer acknowledge, active low
//   nTBI     out  burst inhibit, active low
//   nTEA     out  transfer error acknowledge, active low
//   TERM_OE  out  pad output enable for nTA/nTBI/nTEA
//   BUSY     out  high whenever the sequencer is not idle
//   SEL      out  [1:0] index of the active space, valid while BUSY
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module u409_cycle_term_ctrl #(
    parameter logic [3:0] ROM_WAIT  = 4'd3,
    parameter logic [3:0] CIA_WAIT  = 4'd0,
    parameter logic [3:0] REG_WAIT  = 4'd1,
    parameter logic [3:0] ACFG_WAIT = 4'd1,
    parameter logic [3:0] EXT_MASK  = 4'b0010,
    parameter logic [7:0] TIMEOUT   = 8'd255
) (
    input  logic       CLK40,
    input  logic       nRESET,
    input  logic       TS,
    input  logic [3:0] SPACE,
    input  logic [3:0] EXT_RDY,
    output logic       nTA,
    output logic       nTBI,
    output logic       nTEA,
    output logic       TERM_OE,
    output logic       BUSY,
    output logic [1:0] SEL
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_ACK  = 3'd2,
        ST_ERR  = 3'd3,
        ST_NEG  = 3'd4
    } state_t;

    state_t     state_r;
    logic [3:0] wcnt_r;
    logic [7:0] tocnt_r;

    logic [2:0] space_cnt_s;
    logic [1:0] space_idx_s;
    logic [3:0] load_wait_s;
    logic       ready_s;
    logic       expire_s;

    // Number of space selects asserted; more than one is a decode fault.
    function automatic logic [2:0] space_count(input logic [3:0] space);
        return {2'b00, space[0]} + {2'b00, space[1]} +
               {2'b00, space[2]} + {2'b00, space[3]};
    endfunction

    // One-hot space select to index. Only meaningful for a single bit set.
    function automatic logic [1:0] space_index(input logic [3:0] space);
        logic [1:0] idx;
        case (space)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Wait-state count for a space index.
    function automatic logic [3:0] space_wait(input logic [1:0] idx);
        logic [3:0] w;
        case (idx)
            2'd0:    w = ROM_WAIT;
            2'd1:    w = CIA_WAIT;
            2'd2:    w = REG_WAIT;
            2'd3:    w = ACFG_WAIT;
            default: w = ROM_WAIT;
        endcase
        return w;
    endfunction

    // Decode of the incoming request and the WAIT exit conditions.
    always_comb begin
        space_cnt_s = space_count(SPACE);
        space_idx_s = space_index(SPACE);
        load_wait_s = space_wait(space_idx_s);
        // Ready needs the wait count spent, plus the external ready of the
        // selected space when that space is masked in.
        if (wcnt_r == 4'd0) begin
            ready_s = ~EXT_MASK[SEL] | EXT_RDY[SEL];
        end else begin
            ready_s = 1'b0;
        end
        expire_s = (tocnt_r == (TIMEOUT - 8'd1));
    end

    // Termination state machine with registered pad outputs.
    always_ff @(posedge CLK40 or negedge nRESET) begin
        if (!nRESET) begin
            state_r <= ST_IDLE;
            wcnt_r  <= 4'd0;
            tocnt_r <= 8'd0;
            nTA     <= 1'b1;
            nTBI    <= 1'b1;
            nTEA    <= 1'b1;
            TERM_OE <= 1'b0;
            BUSY    <= 1'b0;
            SEL     <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (TS && (space_cnt_s == 3'd1)) begin
                        state_r <= ST_WAIT;
                        SEL     <= space_idx_s;
                        wcnt_r  <= load_wait_s;
                        tocnt_r <= 8'd0;
                        BUSY    <= 1'b1;
                    end else if (TS && (space_cnt_s != 3'd0)) begin
                        // Two or more spaces claimed the same cycle.
                        state_r <= ST_ERR;
                        wcnt_r  <= 4'd0;
                        tocnt_r <= 8'd0;
                        nTEA    <= 1'b0;
                        TERM_OE <= 1'b1;
                        BUSY    <= 1'b1;
                    end else begin
                        // No request, or a cycle for someone else: stay off the pads.
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // Watchdog count saturates rather than wrapping.
                    if (tocnt_r != 8'hFF) begin
                        tocnt_r <= tocnt_r + 8'd1;
                    end
                    if (ready_s) begin
                        // Acknowledge takes priority over a coincident timeout.
                        state_r <= ST_ACK;
                        nTA     <= 1'b0;
                        nTBI    <= 1'b0;
                        TERM_OE <= 1'b1;
                    end else if (expire_s) begin
                        state_r <= ST_ERR;
                        nTEA    <= 1'b0;
                        TERM_OE <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT;
                        if (wcnt_r != 4'd0) begin
                            wcnt_r <= wcnt_r - 4'd1;
                        end
                    end
                end
                ST_ACK, ST_ERR: begin
                    // Drive all three strobes high for one cycle before release.
                    state_r <= ST_NEG;
                    nTA     <= 1'b1;
                    nTBI    <= 1'b1;
                    nTEA    <= 1'b1;
                    TERM_OE <= 1'b1;
                end
                ST_NEG: begin
                    state_r <= ST_IDLE;
                    TERM_OE <= 1'b0;
                    BUSY    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    wcnt_r  <= 4'd0;
                    tocnt_r <= 8'd0;
                    nTA     <= 1'b1;
                    nTBI    <= 1'b1;
                    nTEA    <= 1'b1;
                    TERM_OE <= 1'b0;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_u409_cycle_term_ctrl.sv
// ----------------------------------------------------------------------------
// tb_u409_cycle_term_ctrl
//
// Table-driven bench. Each record holds the inputs applied before a rising
// edge and the outputs required just after it. Output vectors are packed as
// {nTA, nTBI, nTEA, TERM_OE, BUSY, SEL[1:0]}. Instance dut_a runs with the
// default parameters and dut_b with TIMEOUT=8 for the watchdog case.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_u409_cycle_term_ctrl;

    typedef struct {
        string      name;
        bit         to_b;
        logic       ts;
        logic [3:0] space;
        logic [3:0] ext;
        logic [6:0] exp;
        logic [6:0] care;
    } vec_t;

    logic       CLK40 = 1'b0;
    logic       nRESET;
    logic       ts_a, ts_b;
    logic [3:0] space_a, space_b, ext_a, ext_b;
    logic       nta_a, ntbi_a, ntea_a, oe_a, busy_a;
    logic       nta_b, ntbi_b, ntea_b, oe_b, busy_b;
    logic [1:0] sel_a, sel_b;
    logic [6:0] out_a, out_b;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [6:0] CARE_ALL   = 7'b1111111;
    localparam logic [6:0] CARE_NOSEL = 7'b1111100;
    localparam logic [6:0] P_RESET    = 7'b1110000;

    assign out_a = {nta_a, ntbi_a, ntea_a, oe_a, busy_a, sel_a};
    assign out_b = {nta_b, ntbi_b, ntea_b, oe_b, busy_b, sel_b};

    // 40 MHz bus clock.
    always #12.5 CLK40 = ~CLK40;

    u409_cycle_term_ctrl dut_a (
        .CLK40(CLK40), .nRESET(nRESET), .TS(ts_a), .SPACE(space_a), .EXT_RDY(ext_a),
        .nTA(nta_a), .nTBI(ntbi_a), .nTEA(ntea_a), .TERM_OE(oe_a), .BUSY(busy_a), .SEL(sel_a)
    );

    u409_cycle_term_ctrl #(.TIMEOUT(8'd8)) dut_b (
        .CLK40(CLK40), .nRESET(nRESET), .TS(ts_b), .SPACE(space_b), .EXT_RDY(ext_b),
        .nTA(nta_b), .nTBI(ntbi_b), .nTEA(ntea_b), .TERM_OE(oe_b), .BUSY(busy_b), .SEL(sel_b)
    );

    function automatic logic [6:0] st_idle();
        return 7'b1110000;
    endfunction
    function automatic logic [6:0] st_wait(input logic [1:0] s);
        return {3'b111, 1'b0, 1'b1, s};
    endfunction
    function automatic logic [6:0] st_ack(input logic [1:0] s);
        return {3'b001, 1'b1, 1'b1, s};
    endfunction
    function automatic logic [6:0] st_err(input logic [1:0] s);
        return {3'b110, 1'b1, 1'b1, s};
    endfunction
    function automatic logic [6:0] st_neg(input logic [1:0] s);
        return {3'b111, 1'b1, 1'b1, s};
    endfunction

    task automatic check(input string name, input logic [6:0] act,
                         input logic [6:0] exp, input logic [6:0] care);
        n_checks++;
        if ((act & care) !== (exp & care)) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (care %b)", name, act, exp, care);
        end
    endtask

    // SEL is only compared while BUSY is expected high, unless sel_care is 0.
    task automatic add(input string n, input bit to_b, input logic ts,
                       input logic [3:0] sp, input logic [3:0] ex,
                       input logic [6:0] e, input bit sel_care);
        vec_t v;
        v.name  = n;
        v.to_b  = to_b;
        v.ts    = ts;
        v.space = sp;
        v.ext   = ex;
        v.exp   = e;
        v.care  = (e[2] && sel_care) ? CARE_ALL : CARE_NOSEL;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        if (v.to_b) begin
            ts_b = v.ts;   space_b = v.space; ext_b = v.ext;
            ts_a = 1'b0;   space_a = 4'b0000; ext_a = 4'b0000;
        end else begin
            ts_a = v.ts;   space_a = v.space; ext_a = v.ext;
            ts_b = 1'b0;   space_b = 4'b0000; ext_b = 4'b0000;
        end
        sb_q.push_back(v);
        @(posedge CLK40);
        #1;
        e = sb_q.pop_front();
        check(e.name, e.to_b ? out_b : out_a, e.exp, e.care);
    endtask

    initial begin
        vec_t v;

        // ROM, W=3: TS at edge 0, nTA low edges 4..5, TERM_OE off at edge 6.
        add("rom_ts",   1'b0, 1'b1, 4'b0001, 4'b0000, st_wait(2'd0), 1'b1);
        for (int i = 0; i < 3; i++)
            add("rom_wait", 1'b0, 1'b0, 4'b0000, 4'b0000, st_wait(2'd0), 1'b1);
        add("rom_ack",  1'b0, 1'b0, 4'b0000, 4'b0000, st_ack(2'd0), 1'b1);
        add("rom_neg",  1'b0, 1'b0, 4'b0000, 4'b0000, st_neg(2'd0), 1'b1);
        add("rom_idle", 1'b0, 1'b0, 4'b0000, 4'b0000, st_idle(), 1'b1);
        // Foreign cycle: not claimed, pads stay released.
        add("foreign_ts",   1'b0, 1'b1, 4'b0000, 4'b0000, st_idle(), 1'b1);
        add("foreign_idle", 1'b0, 1'b0, 4'b0000, 4'b0000, st_idle(), 1'b1);
        // Decode fault: two selects at once.
        add("dec_err",  1'b0, 1'b1, 4'b0101, 4'b0000, st_err(2'd0), 1'b0);
        add("dec_neg",  1'b0, 1'b0, 4'b0000, 4'b0000, st_neg(2'd0), 1'b0);
        add("dec_idle", 1'b0, 1'b0, 4'b0000, 4'b0000, st_idle(), 1'b1);
        // REG, W=1, with a second TS during WAIT and another during NEG.
        add("reg_ts",      1'b0, 1'b1, 4'b0100, 4'b0000, st_wait(2'd2), 1'b1);
        add("reg_ts_wait", 1'b0, 1'b1, 4'b0001, 4'b0000, st_wait(2'd2), 1'b1);
        add("reg_ack",     1'b0, 1'b0, 4'b0000, 4'b0000, st_ack(2'd2), 1'b1);
        add("reg_neg",     1'b0, 1'b0, 4'b0000, 4'b0000, st_neg(2'd2), 1'b1);
        add("reg_ts_neg",  1'b0, 1'b1, 4'b0001, 4'b0000, st_idle(), 1'b1);
        // Back-to-back REG straight out of IDLE: nTA low at n+2.
        add("b2b_ts",   1'b0, 1'b1, 4'b0100, 4'b0000, st_wait(2'd2), 1'b1);
        add("b2b_wait", 1'b0, 1'b0, 4'b0000, 4'b0000, st_wait(2'd2), 1'b1);
        add("b2b_ack",  1'b0, 1'b0, 4'b0000, 4'b0000, st_ack(2'd2), 1'b1);
        add("b2b_neg",  1'b0, 1'b0, 4'b0000, 4'b0000, st_neg(2'd2), 1'b1);
        add("b2b_idle", 1'b0, 1'b0, 4'b0000, 4'b0000, st_idle(), 1'b1);
        // ACFG, W=1.
        add("acfg_ts",   1'b0, 1'b1, 4'b1000, 4'b0000, st_wait(2'd3), 1'b1);
        add("acfg_wait", 1'b0, 1'b0, 4'b0000, 4'b0000, st_wait(2'd3), 1'b1);
        add("acfg_ack",  1'b0, 1'b0, 4'b0000, 4'b0000, st_ack(2'd3), 1'b1);
        add("acfg_neg",  1'b0, 1'b0, 4'b0000, 4'b0000, st_neg(2'd3), 1'b1);
        add("acfg_idle", 1'b0, 1'b0, 4'b0000, 4'b0000, st_idle(), 1'b1);
        // CIA: own ready low for 20 cycles while the other readies are high.
        add("cia_ts", 1'b0, 1'b1, 4'b0010, 4'b0000, st_wait(2'd1), 1'b1);
        for (int i = 0; i < 20; i++)
            add("cia_hold", 1'b0, 1'b0, 4'b0000, 4'b1101, st_wait(2'd1), 1'b1);
        add("cia_ack",  1'b0, 1'b0, 4'b0000, 4'b0010, st_ack(2'd1), 1'b1);
        add("cia_neg",  1'b0, 1'b0, 4'b0000, 4'b0000, st_neg(2'd1), 1'b1);
        add("cia_idle", 1'b0, 1'b0, 4'b0000, 4'b0000, st_idle(), 1'b1);
        // Watchdog on dut_b (TIMEOUT=8): ERR on the 8th WAIT edge.
        add("to_ts", 1'b1, 1'b1, 4'b0010, 4'b0000, st_wait(2'd1), 1'b1);
        for (int i = 0; i < 7; i++)
            add("to_wait", 1'b1, 1'b0, 4'b0000, 4'b1101, st_wait(2'd1), 1'b1);
        add("to_err",  1'b1, 1'b0, 4'b0000, 4'b0000, st_err(2'd1), 1'b1);
        add("to_neg",  1'b1, 1'b0, 4'b0000, 4'b0000, st_neg(2'd1), 1'b1);
        add("to_idle", 1'b1, 1'b0, 4'b0000, 4'b0000, st_idle(), 1'b1);

        nRESET = 1'b0;
        ts_a = 1'b0; space_a = 4'b0000; ext_a = 4'b0000;
        ts_b = 1'b0; space_b = 4'b0000; ext_b = 4'b0000;
        repeat (3) @(posedge CLK40);
        #1;
        check("reset_a", out_a, P_RESET, CARE_ALL);
        check("reset_b", out_b, P_RESET, CARE_ALL);
        nRESET = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset in the middle of a ROM WAIT, then a normal REG cycle.
        v = '{name:"mid_ts", to_b:1'b0, ts:1'b1, space:4'b0001, ext:4'b0000,
              exp:st_wait(2'd0), care:CARE_ALL};
        apply(v);
        v.name = "mid_wait"; v.ts = 1'b0; v.space = 4'b0000;
        apply(v);
        #3;
        nRESET = 1'b0;
        #2;
        check("mid_reset_async", out_a, P_RESET, CARE_ALL);
        @(posedge CLK40);
        #1;
        check("mid_reset_hold", out_a, P_RESET, CARE_ALL);
        nRESET = 1'b1;
        v = '{name:"post_ts", to_b:1'b0, ts:1'b1, space:4'b0100, ext:4'b0000,
              exp:st_wait(2'd2), care:CARE_ALL};
        apply(v);
        v.ts = 1'b0; v.space = 4'b0000;
        v.name = "post_wait"; v.exp = st_wait(2'd2); apply(v);
        v.name = "post_ack";  v.exp = st_ack(2'd2);  apply(v);
        v.name = "post_neg";  v.exp = st_neg(2'd2);  apply(v);
        v.name = "post_idle"; v.exp = st_idle(); v.care = CARE_NOSEL; apply(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
